// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the RAM8/RAM64 register-memory family.
//   DATA_WIDTH_DEFAULT : default width of a stored word
//   word_t             : one stored word at the default width
//   RAM8_DEPTH         : words per bank
//   RAM64_DEPTH        : words in a full RAM64 (eight banks)
//   RAM8_ADDR_W        : word-select bits inside one bank
//   RAM64_ADDR_W       : full RAM64 address width
//   RAM64_BANKS        : number of banks in a RAM64
package ram_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

    localparam int RAM8_DEPTH   = 8;
    localparam int RAM64_DEPTH  = 64;
    localparam int RAM8_ADDR_W  = $clog2(RAM8_DEPTH);
    localparam int RAM64_ADDR_W = $clog2(RAM64_DEPTH);
    localparam int RAM64_BANKS  = RAM64_DEPTH / RAM8_DEPTH;

endpackage : ram_pkg

// File: rtl/ram64_ram8.sv
// ram8
// One 8-word bank: eight DATA_WIDTH-bit registers, a write decode and an
// 8:1 combinational read mux.
// Ports:
//   clk     : rising-edge write clock
//   reset   : asynchronous, active-high; clears all eight words
//   load    : write enable, sampled on the clk rising edge
//   address : word select 0..7
//   in      : write data
//   out     : contents of the addressed word (combinational)
module ram8
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    input  logic [DATA_WIDTH-1:0]  in,
    output logic [DATA_WIDTH-1:0]  out
);

    logic [DATA_WIDTH-1:0] word_reg [RAM8_DEPTH];

    // Each word is its own register so reset can clear all of them at once
    // and the read path stays purely combinational.
    generate
        for (genvar gi = 0; gi < RAM8_DEPTH; gi++) begin : g_word
            logic word_we;
            assign word_we = load && (address == RAM8_ADDR_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg[gi] <= '0;
                end else if (word_we) begin
                    word_reg[gi] <= in;
                end
            end
        end
    endgenerate

    // Zero-latency read: a new address shows up on out without a clock edge.
    assign out = word_reg[address];

endmodule : ram8

// File: rtl/ram64.sv
// ram64
// 64-word register memory built from eight ram8 banks.
// address[5:3] picks the bank, address[2:0] the word inside it.
// Ports:
//   clk     : rising-edge write clock
//   reset   : asynchronous, active-high; clears all 64 words
//   load    : write enable, sampled on the clk rising edge
//   address : word select 0..63
//   in      : write data
//   out     : contents of the addressed word (combinational)
module ram64
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [RAM64_ADDR_W-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in,
    output logic [DATA_WIDTH-1:0]   out
);

    localparam int BANK_W = RAM64_ADDR_W - RAM8_ADDR_W;

    logic [BANK_W-1:0]      bank_sel;
    logic [RAM8_ADDR_W-1:0] word_sel;
    logic [RAM64_BANKS-1:0] bank_load;
    logic [DATA_WIDTH-1:0]  bank_out [RAM64_BANKS];

    assign bank_sel = address[RAM64_ADDR_W-1:RAM8_ADDR_W];
    assign word_sel = address[RAM8_ADDR_W-1:0];

    generate
        for (genvar gi = 0; gi < RAM64_BANKS; gi++) begin : g_bank
            // One-hot load demux: only the selected bank ever sees load.
            assign bank_load[gi] = load && (bank_sel == BANK_W'(gi));

            ram8 #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_ram8 (
                .clk     (clk),
                .reset   (reset),
                .load    (bank_load[gi]),
                .address (word_sel),
                .in      (in),
                .out     (bank_out[gi])
            );
        end
    endgenerate

    // 8:1 output mux on the bank field.
    assign out = bank_out[bank_sel];

endmodule : ram64

// File: tb/tb_ram64.sv
// tb_ram64
// Directed, table-driven bench for ram64 plus hand-written sequences for
// read-during-write, combinational address change and asynchronous reset.
module tb_ram64;

    logic        clk;
    logic        reset;
    logic        load;
    logic [5:0]  address;
    logic [15:0] in;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    ram64 #(
        .DATA_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (in),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [5:0]  addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=0x%04h expected=0x%04h", name, address, got, exp);
        end else begin
            $display("ok   %s addr=%0d out=0x%04h", name, address, got);
        end
    endtask

    initial begin
        // ---------------- Reset at power-up ----------------
        reset   = 1'b1;
        load    = 1'b0;
        address = 6'd0;
        in      = 16'h0000;
        #1;
        check("reset_during", out, 16'h0000);
        #9;
        reset = 1'b0;

        // ---------------- Vector table ----------------
        // Each record: inputs applied on the falling edge, out checked 1 ns
        // after the following rising edge at the same address.
        vecs.push_back('{1'b0, 6'd0,  16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd25, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd63, 16'h0000, 16'h0000});
        vecs.push_back('{1'b1, 6'd25, 16'h00FF, 16'h00FF});
        vecs.push_back('{1'b1, 6'd8,  16'hF0F0, 16'hF0F0});
        vecs.push_back('{1'b1, 6'd32, 16'hAAAA, 16'hAAAA});
        vecs.push_back('{1'b0, 6'd25, 16'h0000, 16'h00FF});
        vecs.push_back('{1'b0, 6'd8,  16'h0000, 16'hF0F0});
        vecs.push_back('{1'b0, 6'd32, 16'h0000, 16'hAAAA});
        vecs.push_back('{1'b0, 6'd0,  16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd25, 16'h1234, 16'h00FF});
        vecs.push_back('{1'b0, 6'd25, 16'h1234, 16'h00FF});
        vecs.push_back('{1'b0, 6'd25, 16'h1234, 16'h00FF});
        vecs.push_back('{1'b1, 6'd7,  16'h5555, 16'h5555});
        vecs.push_back('{1'b1, 6'd56, 16'h6666, 16'h6666});
        vecs.push_back('{1'b0, 6'd7,  16'h0000, 16'h5555});
        vecs.push_back('{1'b0, 6'd56, 16'h0000, 16'h6666});
        vecs.push_back('{1'b0, 6'd15, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd48, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd63, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 6'd32, 16'h0000, 16'hAAAA});

        foreach (vecs[i]) begin
            @(negedge clk);
            load    = vecs[i].ld;
            address = vecs[i].addr;
            in      = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), out, vecs[i].exp);
        end

        // ---------------- Combinational address change ----------------
        @(negedge clk);
        load    = 1'b0;
        address = 6'd8;
        #1;
        check("comb_read_8", out, 16'hF0F0);
        address = 6'd7;
        #1;
        check("comb_read_7", out, 16'h5555);

        // ---------------- Read-during-write at 40 ----------------
        @(negedge clk);
        address = 6'd40;
        in      = 16'hBEEF;
        load    = 1'b1;
        #1;
        check("rdw_before", out, 16'h0000);
        @(posedge clk);
        #1;
        check("rdw_after", out, 16'hBEEF);
        @(negedge clk);
        load = 1'b0;

        // ---------------- Asynchronous reset mid-operation ----------------
        #2;
        reset = 1'b1;
        #1;
        check("async_drop", out, 16'h0000);
        // A load edge while reset is held must not write.
        @(negedge clk);
        address = 6'd25;
        in      = 16'h7777;
        load    = 1'b1;
        @(posedge clk);
        #1;
        check("reset_blocks_load", out, 16'h0000);
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        #1;
        check("post_reset_25", out, 16'h0000);
        address = 6'd8;  #1; check("post_reset_8",  out, 16'h0000);
        address = 6'd32; #1; check("post_reset_32", out, 16'h0000);
        address = 6'd7;  #1; check("post_reset_7",  out, 16'h0000);
        address = 6'd56; #1; check("post_reset_56", out, 16'h0000);
        address = 6'd40; #1; check("post_reset_40", out, 16'h0000);

        // Memory still writable after release.
        @(negedge clk);
        address = 6'd63;
        in      = 16'hC3C3;
        load    = 1'b1;
        @(posedge clk);
        #1;
        check("write_after_reset_63", out, 16'hC3C3);
        @(negedge clk);
        load    = 1'b0;
        address = 6'd0;
        #1;
        check("addr0_independent", out, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram64
